// File: rtl/eject_arbiter.sv
// ---------------------------------------------------------------------------
// eject_arbiter
// Merges the six network eject ports into one registered flit stream for the
// processing element. Selection is round-robin between packets. A port that
// wins with a HEAD flit keeps the grant until its TAIL flit has been accepted,
// so the flits of one packet are never interleaved with another port's.
//
// Ports
//   clk_i                   clock, rising edge
//   rst_ni                  asynchronous reset, active low
//   eject_<d>_i             flit from direction d (xpos,ypos,zpos,xneg,yneg,zneg = 0..5)
//   eject_<d>_valid_i       eject_<d>_i holds a flit
//   eject_<d>_ready_o       flit on eject_<d>_i is consumed this cycle
//   pe_flit_o / pe_valid_o  registered flit to the PE
//   pe_ready_i              PE accepts pe_flit_o this cycle
//   pkt_count_o             completed packets accepted, saturating
//   proto_err_o             sticky packet-framing violation flag
//
// FSM states
//   state      | meaning
//   ST_IDLE    | no packet in progress, round-robin scan from rr_ptr+1
//   ST_LOCKED  | packet in progress, only lock_port may transfer
// ---------------------------------------------------------------------------
module eject_arbiter #(
    parameter int         FLIT_SIZE   = 128,
    parameter logic [1:0] HEAD_FLIT   = 2'b00,
    parameter logic [1:0] BODY_FLIT   = 2'b01,
    parameter logic [1:0] TAIL_FLIT   = 2'b10,
    parameter logic [1:0] SINGLE_FLIT = 2'b11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [FLIT_SIZE-1:0] eject_xpos_i,
    input  logic [FLIT_SIZE-1:0] eject_ypos_i,
    input  logic [FLIT_SIZE-1:0] eject_zpos_i,
    input  logic [FLIT_SIZE-1:0] eject_xneg_i,
    input  logic [FLIT_SIZE-1:0] eject_yneg_i,
    input  logic [FLIT_SIZE-1:0] eject_zneg_i,
    input  logic                 eject_xpos_valid_i,
    input  logic                 eject_ypos_valid_i,
    input  logic                 eject_zpos_valid_i,
    input  logic                 eject_xneg_valid_i,
    input  logic                 eject_yneg_valid_i,
    input  logic                 eject_zneg_valid_i,
    output logic                 eject_xpos_ready_o,
    output logic                 eject_ypos_ready_o,
    output logic                 eject_zpos_ready_o,
    output logic                 eject_xneg_ready_o,
    output logic                 eject_yneg_ready_o,
    output logic                 eject_zneg_ready_o,
    output logic [FLIT_SIZE-1:0] pe_flit_o,
    output logic                 pe_valid_o,
    input  logic                 pe_ready_i,
    output logic [15:0]          pkt_count_o,
    output logic                 proto_err_o
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t               state_q, state_d;
    logic [2:0]           lock_port_q, lock_port_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [FLIT_SIZE-1:0] pe_flit_q, pe_flit_d;
    logic                 pe_valid_q, pe_valid_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic                 proto_err_q, proto_err_d;

    logic [FLIT_SIZE-1:0] flit_vec [6];
    logic [5:0]           valid_vec;
    logic [5:0]           ready_vec;

    logic [3:0]           scan_sum;
    logic                 scan_found;
    logic [2:0]           scan_port;
    logic [2:0]           sel_port;
    logic                 sel_valid;
    logic [FLIT_SIZE-1:0] sel_flit;
    logic [1:0]           sel_type;
    logic                 load;
    logic                 take;

    assign flit_vec[0] = eject_xpos_i;
    assign flit_vec[1] = eject_ypos_i;
    assign flit_vec[2] = eject_zpos_i;
    assign flit_vec[3] = eject_xneg_i;
    assign flit_vec[4] = eject_yneg_i;
    assign flit_vec[5] = eject_zneg_i;

    assign valid_vec = {eject_zneg_valid_i, eject_yneg_valid_i, eject_xneg_valid_i,
                        eject_zpos_valid_i, eject_ypos_valid_i, eject_xpos_valid_i};

    // Scan from the farthest candidate back to the nearest so the last hit,
    // i.e. the first valid port after rr_ptr, wins.
    always_comb begin
        scan_found = 1'b0;
        scan_port  = 3'd0;
        scan_sum   = 4'd0;
        for (int k = 6; k >= 1; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + 4'(k);
            if (scan_sum >= 4'd6) begin
                scan_sum = scan_sum - 4'd6;
            end
            if (valid_vec[scan_sum[2:0]]) begin
                scan_found = 1'b1;
                scan_port  = scan_sum[2:0];
            end
        end
    end

    assign sel_port  = (state_q == ST_LOCKED) ? lock_port_q : scan_port;
    assign sel_valid = (state_q == ST_LOCKED) ? valid_vec[lock_port_q] : scan_found;
    assign sel_flit  = flit_vec[sel_port];
    assign sel_type  = sel_flit[FLIT_SIZE-1 -: 2];

    // Ready is gated by reset so no source sees a consume while held in reset.
    assign load      = !pe_valid_q || pe_ready_i;
    assign take      = rst_ni && load && sel_valid;
    assign ready_vec = take ? (6'b000001 << sel_port) : 6'b000000;

    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        pe_flit_d   = pe_flit_q;
        pe_valid_d  = pe_valid_q;
        pkt_count_d = pkt_count_q;
        proto_err_d = proto_err_q;

        if (load) begin
            pe_valid_d = 1'b0;
        end

        if (take) begin
            if (state_q == ST_IDLE) begin
                if (sel_type == HEAD_FLIT) begin
                    pe_flit_d   = sel_flit;
                    pe_valid_d  = 1'b1;
                    lock_port_d = sel_port;
                    state_d     = ST_LOCKED;
                end else if (sel_type == SINGLE_FLIT) begin
                    pe_flit_d  = sel_flit;
                    pe_valid_d = 1'b1;
                    rr_ptr_d   = sel_port;
                    if (pkt_count_q != 16'hFFFF) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end else begin
                    // Orphan BODY/TAIL: consume it so the port drains, but drop it.
                    proto_err_d = 1'b1;
                    rr_ptr_d    = sel_port;
                end
            end else begin
                pe_flit_d  = sel_flit;
                pe_valid_d = 1'b1;
                if (sel_type == TAIL_FLIT) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = lock_port_q;
                    if (pkt_count_q != 16'hFFFF) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end else if (sel_type != BODY_FLIT) begin
                    // HEAD or SINGLE inside a packet is forwarded but does not end it.
                    proto_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            lock_port_q <= 3'd0;
            rr_ptr_q    <= 3'd5;
            pe_flit_q   <= '0;
            pe_valid_q  <= 1'b0;
            pkt_count_q <= 16'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            pe_flit_q   <= pe_flit_d;
            pe_valid_q  <= pe_valid_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign eject_xpos_ready_o = ready_vec[0];
    assign eject_ypos_ready_o = ready_vec[1];
    assign eject_zpos_ready_o = ready_vec[2];
    assign eject_xneg_ready_o = ready_vec[3];
    assign eject_yneg_ready_o = ready_vec[4];
    assign eject_zneg_ready_o = ready_vec[5];

    assign pe_flit_o   = pe_flit_q;
    assign pe_valid_o  = pe_valid_q;
    assign pkt_count_o = pkt_count_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_eject_arbiter.sv
module tb_eject_arbiter;

    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] SG = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] fl [6];
    logic [5:0]   vl = 6'b0;
    logic         pe_ready = 1'b1;
    wire  [5:0]   rd;
    wire  [127:0] pe_flit;
    wire          pe_valid;
    wire  [15:0]  pkt_count;
    wire          proto_err;

    int checks = 0;
    int errors = 0;

    // reference model: packet ownership and last-served port, plain ints
    int           m_owner;
    int           m_last;
    logic         m_pv;
    logic [127:0] m_flit;
    int           m_cnt;
    logic         m_err;
    logic [127:0] outq [$];

    always #5 clk = ~clk;

    eject_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .eject_xpos_i(fl[0]), .eject_ypos_i(fl[1]), .eject_zpos_i(fl[2]),
        .eject_xneg_i(fl[3]), .eject_yneg_i(fl[4]), .eject_zneg_i(fl[5]),
        .eject_xpos_valid_i(vl[0]), .eject_ypos_valid_i(vl[1]), .eject_zpos_valid_i(vl[2]),
        .eject_xneg_valid_i(vl[3]), .eject_yneg_valid_i(vl[4]), .eject_zneg_valid_i(vl[5]),
        .eject_xpos_ready_o(rd[0]), .eject_ypos_ready_o(rd[1]), .eject_zpos_ready_o(rd[2]),
        .eject_xneg_ready_o(rd[3]), .eject_yneg_ready_o(rd[4]), .eject_zneg_ready_o(rd[5]),
        .pe_flit_o(pe_flit), .pe_valid_o(pe_valid), .pe_ready_i(pe_ready),
        .pkt_count_o(pkt_count), .proto_err_o(proto_err)
    );

    typedef struct {
        logic [5:0] vld;
        logic [1:0] typ;
        logic       prdy;
        logic [5:0] e_rdy;
        logic       e_pv;
        int         e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [1:0] t, input logic [125:0] payload);
        return {t, payload};
    endfunction

    function automatic logic [125:0] rnd_payload();
        return {$urandom, $urandom, $urandom, 30'($urandom)};
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_last  = 5;
        m_pv    = 1'b0;
        m_flit  = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
        outq.delete();
    endtask

    function automatic int m_grant();
        int g;
        g = -1;
        if (!m_pv || pe_ready) begin
            if (m_owner >= 0) begin
                if (vl[m_owner]) g = m_owner;
            end else begin
                for (int k = 1; k <= 6; k++) begin
                    if (g < 0 && vl[(m_last + k) % 6]) g = (m_last + k) % 6;
                end
            end
        end
        return g;
    endfunction

    // Compare DUT against the model for the current cycle, then advance the
    // model across the coming rising edge.
    task automatic step(input string tag);
        int         g;
        logic [5:0] er;
        logic [1:0] t;
        g  = m_grant();
        er = (g >= 0) ? (6'b000001 << g) : 6'b000000;
        chk({tag, " ready"}, 128'(rd), 128'(er));
        chk({tag, " pe_valid"}, 128'(pe_valid), 128'(m_pv));
        if (m_pv) chk({tag, " pe_flit"}, pe_flit, m_flit);
        chk({tag, " pkt_count"}, 128'(pkt_count), 128'(m_cnt));
        chk({tag, " proto_err"}, 128'(proto_err), 128'(m_err));
        if (pe_valid && pe_ready) outq.push_back(pe_flit);
        if (!m_pv || pe_ready) m_pv = 1'b0;
        if (g >= 0) begin
            t = fl[g][127:126];
            if (m_owner < 0) begin
                if (t == HD) begin
                    m_pv = 1'b1; m_flit = fl[g]; m_owner = g;
                end else if (t == SG) begin
                    m_pv = 1'b1; m_flit = fl[g]; m_last = g;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_err = 1'b1; m_last = g;
                end
            end else begin
                m_pv = 1'b1; m_flit = fl[g];
                if (t == TL) begin
                    m_owner = -1; m_last = g;
                    if (m_cnt < 65535) m_cnt++;
                end else if (t != BD) begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vl = 6'b0;
        pe_ready = 1'b1;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] pkt [16];
        int           idx;
        int           n;

        for (int p = 0; p < 6; p++) fl[p] = mk(SG, 126'(p));
        m_reset();

        // async reset state, with every source asserting valid
        vl = 6'b111111;
        #3;
        chk("rst ready", 128'(rd), 128'(0));
        chk("rst pe_valid", 128'(pe_valid), 128'(0));
        chk("rst pe_flit", pe_flit, 128'(0));
        chk("rst pkt_count", 128'(pkt_count), 128'(0));
        chk("rst proto_err", 128'(proto_err), 128'(0));
        vl = 6'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // contention round-robin, backpressure, orphan BODY
        tbl[0]  = '{6'b111111, SG, 1'b1, 6'b000001, 1'b0, 0, 1'b0};
        tbl[1]  = '{6'b111111, SG, 1'b1, 6'b000010, 1'b1, 1, 1'b0};
        tbl[2]  = '{6'b111111, SG, 1'b1, 6'b000100, 1'b1, 2, 1'b0};
        tbl[3]  = '{6'b111111, SG, 1'b1, 6'b001000, 1'b1, 3, 1'b0};
        tbl[4]  = '{6'b111111, SG, 1'b1, 6'b010000, 1'b1, 4, 1'b0};
        tbl[5]  = '{6'b111111, SG, 1'b1, 6'b100000, 1'b1, 5, 1'b0};
        tbl[6]  = '{6'b111111, SG, 1'b1, 6'b000001, 1'b1, 6, 1'b0};
        tbl[7]  = '{6'b000000, SG, 1'b1, 6'b000000, 1'b1, 7, 1'b0};
        tbl[8]  = '{6'b111111, SG, 1'b0, 6'b000010, 1'b0, 7, 1'b0};
        tbl[9]  = '{6'b111111, SG, 1'b0, 6'b000000, 1'b1, 8, 1'b0};
        tbl[10] = '{6'b111111, SG, 1'b0, 6'b000000, 1'b1, 8, 1'b0};
        tbl[11] = '{6'b111111, SG, 1'b1, 6'b000100, 1'b1, 8, 1'b0};
        tbl[12] = '{6'b001000, BD, 1'b1, 6'b001000, 1'b1, 9, 1'b0};
        tbl[13] = '{6'b000000, SG, 1'b1, 6'b000000, 1'b0, 9, 1'b1};
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            vl = tbl[r].vld;
            pe_ready = tbl[r].prdy;
            for (int p = 0; p < 6; p++) fl[p] = mk(tbl[r].typ, 126'(p));
            #1;
            chk($sformatf("tbl%0d ready", r), 128'(rd), 128'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d pe_valid", r), 128'(pe_valid), 128'(tbl[r].e_pv));
            chk($sformatf("tbl%0d pkt_count", r), 128'(pkt_count), 128'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d proto_err", r), 128'(proto_err), 128'(tbl[r].e_err));
        end

        // single 16-flit packet on xpos, then lock of ypos against zneg
        do_reset();
        for (int k = 0; k < 16; k++)
            pkt[k] = mk((k == 0) ? HD : (k == 15) ? TL : BD, rnd_payload());
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vl = 6'b000001;
            fl[0] = pkt[k];
            #1;
            chk($sformatf("pkt ready%0d", k), 128'(rd), 128'(6'b000001));
            if (k > 0) chk($sformatf("pkt flit%0d", k - 1), pe_flit, pkt[k - 1]);
            step("pkt");
        end
        @(negedge clk);
        vl = 6'b0;
        #1;
        chk("pkt last flit", pe_flit, pkt[15]);
        chk("pkt count", 128'(pkt_count), 128'(1));
        step("pkt");

        fl[5] = mk(SG, rnd_payload());
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vl = 6'b100010;
            fl[1] = mk((k == 0) ? HD : (k == 4) ? TL : BD, rnd_payload());
            #1;
            chk($sformatf("lock ready%0d", k), 128'(rd), 128'(6'b000010));
            step("lock");
        end
        @(negedge clk);
        fl[1] = mk(SG, rnd_payload());
        #1;
        chk("lock zneg next", 128'(rd), 128'(6'b100000));
        step("lock");
        @(negedge clk);
        vl = 6'b0;
        #1;
        chk("lock count", 128'(pkt_count), 128'(3));
        step("lock");

        // backpressure mid-packet: nothing lost, nothing duplicated
        do_reset();
        for (int k = 0; k < 6; k++)
            pkt[k] = mk((k == 0) ? HD : (k == 5) ? TL : BD, rnd_payload());
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vl = (idx < 6) ? 6'b000001 : 6'b000000;
            fl[0] = (idx < 6) ? pkt[idx] : '0;
            pe_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            #1;
            if (c >= 2 && c <= 6) begin
                chk($sformatf("bp stall ready%0d", c), 128'(rd), 128'(0));
                chk($sformatf("bp stall flit%0d", c), pe_flit, pkt[1]);
            end
            if (rd[0]) idx++;
            step("bp");
        end
        n = outq.size();
        chk("bp delivered", 128'(n), 128'(6));
        for (int k = 0; k < 6; k++)
            if (k < n) chk($sformatf("bp order%0d", k), outq[k], pkt[k]);

        // reset mid-packet
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vl = 6'b000001;
            fl[0] = mk((k == 0) ? HD : BD, rnd_payload());
            #1;
            step("mid");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst pe_valid", 128'(pe_valid), 128'(0));
        chk("mid rst pkt_count", 128'(pkt_count), 128'(0));
        chk("mid rst ready", 128'(rd), 128'(0));
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        vl = 6'b000101;
        fl[0] = mk(HD, rnd_payload());
        fl[2] = mk(HD, rnd_payload());
        #1;
        chk("mid regrant", 128'(rd), 128'(6'b000001));
        step("mid");

        // randomized traffic against the model
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                vl = 6'($urandom);
                pe_ready = ($urandom_range(0, 3) != 0);
                for (int p = 0; p < 6; p++) begin
                    n = $urandom_range(0, 9);
                    fl[p] = mk((n < 2) ? HD : (n < 7) ? BD : (n < 9) ? TL : SG, rnd_payload());
                end
                #1;
                step("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eject_arbiter.md
EJECT_ARBITER -- requirements
Module: eject_arbiter

Interface
REQ-001 Parameter FLIT_SIZE, default 128, flit width in bits.
REQ-002 Parameter HEAD_FLIT, default 2'b00, type code for a head flit.
REQ-003 Parameter BODY_FLIT, default 2'b01, type code for a body flit.
REQ-004 Parameter TAIL_FLIT, default 2'b10, type code for a tail flit.
REQ-005 Parameter SINGLE_FLIT, default 2'b11, type code for a one-flit packet (head and tail).
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  reset, asynchronous assert, active-low.
REQ-009 eject_<d>  input  FLIT_SIZE  ejected flit from direction d; d in {xpos, ypos, zpos, xneg, yneg, zneg}, port index 0..5 in that order.
REQ-010 eject_<d>_valid  input  1  eject_<d> holds a flit.
REQ-011 eject_<d>_ready  output  1  the flit on eject_<d> is consumed this cycle.
REQ-012 pe_flit  output  FLIT_SIZE  registered flit to the processing element.
REQ-013 pe_valid  output  1  pe_flit is valid.
REQ-014 pe_ready  input  1  the PE accepts pe_flit this cycle.
REQ-015 pkt_count  output  16  count of completed packets delivered; saturating.
REQ-016 proto_err  output  1  sticky flag: a packet-framing violation was seen.

Function
REQ-017 Flit type is flit[FLIT_SIZE-1 -: 2].
REQ-018 A transfer on input i occurs when eject_i_valid and eject_i_ready are both 1.
REQ-019 A transfer on the output occurs when pe_valid and pe_ready are both 1.
REQ-020 Output load enable: load = !pe_valid || pe_ready.
REQ-021 At most one eject_i_ready is 1 per cycle.
REQ-022 eject_i_ready is 1 only when load is 1, input i is the selected port, and eject_i_valid is 1.
REQ-023 On an input transfer, pe_flit <= that flit and pe_valid <= 1 at the next edge; latency is 1 cycle.
REQ-024 When load is 1 and there is no input transfer, pe_valid <= 0.
REQ-025 While pe_valid=1 and pe_ready=0, pe_flit and pe_valid are held stable.
REQ-026 A new flit may load in the same cycle the old one is consumed, giving full throughput of 1 flit/cycle.
REQ-027 The FSM has two states, IDLE and LOCKED, plus a 3-bit lock_port and a 3-bit rr_ptr.
REQ-028 IDLE selection: the first valid port scanning rr_ptr+1, rr_ptr+2, ... modulo 6 (wrap 5->0).
REQ-029 IDLE, selected flit is HEAD: accept it, lock_port <= selected port, go to LOCKED.
REQ-030 IDLE, selected flit is SINGLE: accept it, rr_ptr <= selected port, stay in IDLE, increment pkt_count.
REQ-031 IDLE, selected flit is BODY or TAIL: accept and discard it (not loaded to the output), proto_err <= 1, rr_ptr <= that port.
REQ-032 LOCKED: only lock_port is eligible; all other ports see ready=0 regardless of their valid.
REQ-033 LOCKED, BODY accepted: stay in LOCKED.
REQ-034 LOCKED, TAIL accepted: go to IDLE, rr_ptr <= lock_port, increment pkt_count.
REQ-035 LOCKED, HEAD or SINGLE received on lock_port: forward it, proto_err <= 1, remain LOCKED; a SINGLE does not end the packet.
REQ-036 LOCKED with lock_port not valid: no transfer, no state change; no timeout.
REQ-037 pkt_count saturates at 16'hFFFF.
REQ-038 pkt_count increments when the TAIL or SINGLE flit is accepted on the input, not when it leaves the output.
REQ-039 The arbiter does not modify flit contents.

Reset
REQ-040 While rst=0, reset values apply immediately (asynchronously): state=IDLE, rr_ptr=5 (so port 0 has first priority), lock_port=0, pe_valid=0, pe_flit=0, pkt_count=0, proto_err=0.
REQ-041 While rst=0, all eject_i_ready are 0.
REQ-042 Reset asserted mid-packet abandons the packet; after release, the next flit from that port is treated per IDLE rules.

Verification
REQ-043 Single packet: xpos sends HEAD,BODY×14,TAIL with pe_ready=1 -> 16 flits out in order, 1-cycle latency, pkt_count=1, state returns to IDLE.
REQ-044 Contention: after reset, all 6 ports hold SINGLE flits -> grant order 0,1,2,3,4,5,0,...; pkt_count=6 after 6 cycles.
REQ-045 Lock: ypos is mid-packet while zneg is valid -> zneg_ready stays 0 until ypos TAIL is accepted; zneg is granted next.
REQ-046 Backpressure: pe_ready=0 for 5 cycles mid-packet -> pe_flit stable, no ready asserted, no flit lost or duplicated.
REQ-047 Framing: BODY on xneg while IDLE -> flit dropped, proto_err=1, pe_valid stays 0.
REQ-048 Reset mid-packet (rst low after 3 of 16 flits) -> pe_valid=0 and pkt_count=0 immediately; the next HEAD on any port is granted per rr_ptr=5.
